// File: rtl/fdn_pipe.sv
// fdn_pipe: parametrised, stallable, flushable register pipeline.
// Each data word travels with its own valid bit. An occupancy count and an
// empty flag track how many stages currently hold a valid word.
// Every output comes straight from a flop, so there is no combinational path
// from D, VI, CE or FL to any output.
module fdn_pipe #(
    parameter int                 WIDTH = 4,
    parameter int                 DEPTH = 1,
    parameter logic [WIDTH-1:0]   INIT  = {WIDTH{1'b0}},
    parameter int                 CNTW  = $clog2(DEPTH + 1)
) (
    input  logic              CK,
    input  logic              CLR,
    input  logic              CE,
    input  logic              FL,
    input  logic [WIDTH-1:0]  D,
    input  logic              VI,
    output logic [WIDTH-1:0]  Q,
    output logic              VO,
    output logic [CNTW-1:0]   CNT,
    output logic              EMPTY
);

    logic [DEPTH-1:0][WIDTH-1:0] s_q;
    logic [DEPTH-1:0][WIDTH-1:0] s_d;
    logic [DEPTH-1:0]            v_q;
    logic [DEPTH-1:0]            v_d;
    logic [CNTW-1:0]             cnt_q;
    logic [CNTW-1:0]             cnt_d;
    logic                        empty_q;
    logic                        empty_d;

    // Next-state: a flush beats an advance, and with neither the state holds.
    always_comb begin
        s_d   = s_q;
        v_d   = v_q;
        cnt_d = cnt_q;
        if (FL) begin
            // Only the valid bits are dropped; the data stays where it is.
            v_d   = {DEPTH{1'b0}};
            cnt_d = {CNTW{1'b0}};
        end else if (CE) begin
            s_d[0] = D;
            v_d[0] = VI;
            for (int i = 1; i < DEPTH; i++) begin
                s_d[i] = s_q[i-1];
                v_d[i] = v_q[i-1];
            end
            // A valid word entering and a valid word leaving on the same
            // edge cancel out, so the count never wraps.
            if (VI && !v_q[DEPTH-1]) begin
                cnt_d = cnt_q + CNTW'(1);
            end else if (!VI && v_q[DEPTH-1]) begin
                cnt_d = cnt_q - CNTW'(1);
            end else begin
                cnt_d = cnt_q;
            end
        end else begin
            s_d   = s_q;
            v_d   = v_q;
            cnt_d = cnt_q;
        end
    end

    // The empty flag is computed from the next count so that it is registered
    // in step with CNT.
    always_comb begin
        empty_d = 1'b0;
        if (cnt_d == {CNTW{1'b0}}) begin
            empty_d = 1'b1;
        end else begin
            empty_d = 1'b0;
        end
    end

    // State registers. A synchronous clear overrides everything else,
    // including a flush on the same edge.
    always_ff @(posedge CK) begin
        if (CLR) begin
            for (int i = 0; i < DEPTH; i++) begin
                s_q[i] <= INIT;
            end
            v_q     <= {DEPTH{1'b0}};
            cnt_q   <= {CNTW{1'b0}};
            empty_q <= 1'b1;
        end else begin
            s_q     <= s_d;
            v_q     <= v_d;
            cnt_q   <= cnt_d;
            empty_q <= empty_d;
        end
    end

    // The outputs are the last stage and the count flops, with no logic added.
    assign Q     = s_q[DEPTH-1];
    assign VO    = v_q[DEPTH-1];
    assign CNT   = cnt_q;
    assign EMPTY = empty_q;

endmodule

// File: tb/tb_fdn_pipe.sv
// Directed self-checking bench for fdn_pipe.
// The main instance is WIDTH=8, DEPTH=3, INIT=A5. A second instance with
// DEPTH=1, INIT=3C shares the same inputs.
// Packed compare vector for the main instance: {Q[7:0], VO, CNT[1:0], EMPTY}.
module tb_fdn_pipe;

    logic       ck;
    logic       clr;
    logic       ce;
    logic       fl;
    logic [7:0] d;
    logic       vi;
    logic [7:0] q;
    logic       vo;
    logic [1:0] cnt;
    logic       empty;
    logic [7:0] q1;
    logic       vo1;
    logic [0:0] cnt1;
    logic       empty1;

    int n_checks;
    int n_fails;

    fdn_pipe #(.WIDTH(8), .DEPTH(3), .INIT(8'hA5)) dut (
        .CK(ck), .CLR(clr), .CE(ce), .FL(fl), .D(d), .VI(vi),
        .Q(q), .VO(vo), .CNT(cnt), .EMPTY(empty)
    );

    fdn_pipe #(.WIDTH(8), .DEPTH(1), .INIT(8'h3C)) dut1 (
        .CK(ck), .CLR(clr), .CE(ce), .FL(fl), .D(d), .VI(vi),
        .Q(q1), .VO(vo1), .CNT(cnt1), .EMPTY(empty1)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    // Apply the inputs for one edge, then let the outputs settle just after it.
    task automatic step(input logic c_clr, input logic c_fl, input logic c_ce,
                        input logic [7:0] c_d, input logic c_vi);
        clr = c_clr; fl = c_fl; ce = c_ce; d = c_d; vi = c_vi;
        @(posedge ck);
        #1;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 1'b1, 8'hFF, 1'b1);
        n_checks++;
        if ({q, vo, cnt, empty} !== {8'hA5, 1'b0, 2'd0, 1'b1}) begin
            n_fails++;
            $display("FAIL reset: got q=%h vo=%b cnt=%0d empty=%b, expected q=a5 vo=0 cnt=0 empty=1",
                     q, vo, cnt, empty);
        end
        n_checks++;
        if ({q1, vo1, cnt1, empty1} !== {8'h3C, 1'b0, 1'b0, 1'b1}) begin
            n_fails++;
            $display("FAIL reset_d1: got q=%h vo=%b cnt=%0d empty=%b, expected q=3c vo=0 cnt=0 empty=1",
                     q1, vo1, cnt1, empty1);
        end
    endtask

    task automatic test_stream();
        logic [11:0] exp;
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 1; i <= 6; i++) begin
            step(1'b0, 1'b0, 1'b1, 8'(i), 1'b1);
            if (i >= 3) exp = {8'(i - 2), 1'b1, 2'd3, 1'b0};
            else        exp = {8'hA5, 1'b0, 2'(i), 1'b0};
            n_checks++;
            if ({q, vo, cnt, empty} !== exp) begin
                n_fails++;
                $display("FAIL stream[%0d]: got %h_%b_%0d_%b, expected %h", i, q, vo, cnt, empty, exp);
            end
        end
    endtask

    task automatic test_stall();
        logic [11:0] exp [0:8];
        exp[0] = {8'hA5, 1'b0, 2'd1, 1'b0};
        exp[1] = {8'hA5, 1'b0, 2'd2, 1'b0};
        exp[2] = {8'hA5, 1'b0, 2'd2, 1'b0};
        exp[3] = {8'hA5, 1'b0, 2'd2, 1'b0};
        exp[4] = {8'h01, 1'b1, 2'd3, 1'b0};
        exp[5] = {8'h02, 1'b1, 2'd3, 1'b0};
        exp[6] = {8'h03, 1'b1, 2'd2, 1'b0};
        exp[7] = {8'h04, 1'b1, 2'd1, 1'b0};
        exp[8] = {8'h00, 1'b0, 2'd0, 1'b1};
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i <= 8; i++) begin
            case (i)
                0:       step(1'b0, 1'b0, 1'b1, 8'h01, 1'b1);
                1:       step(1'b0, 1'b0, 1'b1, 8'h02, 1'b1);
                2, 3:    step(1'b0, 1'b0, 1'b0, 8'hEE, 1'b1);
                4:       step(1'b0, 1'b0, 1'b1, 8'h03, 1'b1);
                5:       step(1'b0, 1'b0, 1'b1, 8'h04, 1'b1);
                default: step(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
            endcase
            n_checks++;
            if ({q, vo, cnt, empty} !== exp[i]) begin
                n_fails++;
                $display("FAIL stall[%0d]: got %h_%b_%0d_%b, expected %h", i, q, vo, cnt, empty, exp[i]);
            end
        end
    endtask

    task automatic test_flush();
        logic [7:0] exp_q [0:2];
        exp_q[0] = 8'h22; exp_q[1] = 8'h33; exp_q[2] = 8'h00;
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'h11, 1'b1);
        step(1'b0, 1'b0, 1'b1, 8'h22, 1'b1);
        step(1'b0, 1'b0, 1'b1, 8'h33, 1'b1);
        n_checks++;
        if ({q, vo, cnt, empty} !== {8'h11, 1'b1, 2'd3, 1'b0}) begin
            n_fails++;
            $display("FAIL flush_fill: got %h_%b_%0d_%b, expected 11_1_3_0", q, vo, cnt, empty);
        end
        step(1'b0, 1'b1, 1'b1, 8'hFF, 1'b1);
        n_checks++;
        if ({q, vo, cnt, empty} !== {8'h11, 1'b0, 2'd0, 1'b1}) begin
            n_fails++;
            $display("FAIL flush: got %h_%b_%0d_%b, expected 11_0_0_1", q, vo, cnt, empty);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
            n_checks++;
            if ({q, vo, cnt, empty} !== {exp_q[i], 1'b0, 2'd0, 1'b1}) begin
                n_fails++;
                $display("FAIL flush_drain[%0d]: got %h_%b_%0d_%b, expected %h_0_0_1",
                         i, q, vo, cnt, empty, exp_q[i]);
            end
        end
    endtask

    task automatic test_valid_pattern();
        logic [7:0]  dv [0:5];
        logic        vv [0:5];
        logic [11:0] exp [0:5];
        dv[0] = 8'h10; dv[1] = 8'h20; dv[2] = 8'h30; dv[3] = 8'h00; dv[4] = 8'h00; dv[5] = 8'h00;
        vv[0] = 1'b1;  vv[1] = 1'b0;  vv[2] = 1'b1;  vv[3] = 1'b0;  vv[4] = 1'b0;  vv[5] = 1'b0;
        exp[0] = {8'hA5, 1'b0, 2'd1, 1'b0};
        exp[1] = {8'hA5, 1'b0, 2'd1, 1'b0};
        exp[2] = {8'h10, 1'b1, 2'd2, 1'b0};
        exp[3] = {8'h20, 1'b0, 2'd1, 1'b0};
        exp[4] = {8'h30, 1'b1, 2'd1, 1'b0};
        exp[5] = {8'h00, 1'b0, 2'd0, 1'b1};
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0, 1'b1, dv[i], vv[i]);
            n_checks++;
            if ({q, vo, cnt, empty} !== exp[i]) begin
                n_fails++;
                $display("FAIL vpat[%0d]: got %h_%b_%0d_%b, expected %h", i, q, vo, cnt, empty, exp[i]);
            end
        end
    endtask

    task automatic test_clr_fl();
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'h5A, 1'b1);
        step(1'b0, 1'b0, 1'b1, 8'h6B, 1'b1);
        step(1'b1, 1'b1, 1'b1, 8'h7C, 1'b1);
        n_checks++;
        if ({q, vo, cnt, empty} !== {8'hA5, 1'b0, 2'd0, 1'b1}) begin
            n_fails++;
            $display("FAIL clr_fl: got %h_%b_%0d_%b, expected a5_0_0_1", q, vo, cnt, empty);
        end
        // The inner stages must also have been loaded with INIT, not just held.
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
            n_checks++;
            if ({q, vo, cnt, empty} !== {8'hA5, 1'b0, 2'd0, 1'b1}) begin
                n_fails++;
                $display("FAIL clr_fl_init[%0d]: got %h_%b_%0d_%b, expected a5_0_0_1", i, q, vo, cnt, empty);
            end
        end
    endtask

    task automatic test_depth1();
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'h5A, 1'b1);
        n_checks++;
        if ({q1, vo1, cnt1, empty1} !== {8'h5A, 1'b1, 1'b1, 1'b0}) begin
            n_fails++;
            $display("FAIL d1_load: got %h_%b_%0d_%b, expected 5a_1_1_0", q1, vo1, cnt1, empty1);
        end
        step(1'b0, 1'b0, 1'b0, 8'h77, 1'b1);
        n_checks++;
        if ({q1, vo1, cnt1, empty1} !== {8'h5A, 1'b1, 1'b1, 1'b0}) begin
            n_fails++;
            $display("FAIL d1_hold: got %h_%b_%0d_%b, expected 5a_1_1_0", q1, vo1, cnt1, empty1);
        end
        step(1'b0, 1'b0, 1'b1, 8'h77, 1'b1);
        n_checks++;
        if ({q1, vo1, cnt1, empty1} !== {8'h77, 1'b1, 1'b1, 1'b0}) begin
            n_fails++;
            $display("FAIL d1_inout: got %h_%b_%0d_%b, expected 77_1_1_0", q1, vo1, cnt1, empty1);
        end
        step(1'b0, 1'b0, 1'b1, 8'h88, 1'b0);
        n_checks++;
        if ({q1, vo1, cnt1, empty1} !== {8'h88, 1'b0, 1'b0, 1'b1}) begin
            n_fails++;
            $display("FAIL d1_invalid: got %h_%b_%0d_%b, expected 88_0_0_1", q1, vo1, cnt1, empty1);
        end
    endtask

    // Run the scenarios in order, then print the summary line.
    initial begin
        n_checks = 0;
        n_fails  = 0;
        clr = 1'b0; fl = 1'b0; ce = 1'b0; d = 8'h00; vi = 1'b0;
        test_reset();
        test_stream();
        test_stall();
        test_flush();
        test_valid_pattern();
        test_clr_fl();
        test_depth1();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/fdn_pipe.md
# fdn_pipe

Parametrised clock-enabled register pipeline, the successor to the fixed 4-bit enabled register used across the datapath. It generalises width and depth, adds a valid bit that travels with each data word, a synchronous clear, a valid-only flush and an occupancy count. It sits between datapath stages wherever a stallable, flushable N-cycle delay of a data bus is needed.

## Interface
- WIDTH, 4, data bus width in bits (≥1)
- DEPTH, 1, number of register stages (≥1); DEPTH=1 gives a single enabled register
- INIT, 0, WIDTH-bit value loaded into every data stage on reset
- CNTW, $clog2(DEPTH+1), width of occupancy count

- CK  in  1  clock, all state updates on rising edge
- CLR  in  1  reset, synchronous, active-high; clears all state
- CE  in  1  clock enable; 1 advances the pipeline by one stage
- FL  in  1  flush; synchronously invalidates all stages, data held
- D  in  WIDTH  data into stage 0
- VI  in  1  valid qualifier for D
- Q  out  WIDTH  data of last stage (DEPTH-1)
- VO  out  1  valid bit of last stage
- CNT  out  CNTW  number of stages currently holding a valid word (0..DEPTH)
- EMPTY  out  1  1 when CNT==0

## Operation
- State: data stages s[0..DEPTH-1] (WIDTH each), valid bits v[0..DEPTH-1], counter CNT.
- Priority per edge: CLR > FL > CE > hold.
- CLR=1: all s[i] <= INIT, all v[i] <= 0, CNT <= 0. CE, FL, D, VI ignored.
- FL=1, CLR=0: all v[i] <= 0, CNT <= 0; s[i] unchanged; CE ignored that cycle (the word on D/VI is dropped).
- CE=1, CLR=0, FL=0: s[0] <= D, v[0] <= VI; s[i] <= s[i-1], v[i] <= v[i-1] for i≥1. Word in last stage is discarded.
- CNT on advance: CNT <= CNT + VI − v[DEPTH-1]; result always within 0..DEPTH, no wrap. Simultaneous VI=1 and v[DEPTH-1]=1: CNT unchanged.
- CE=0, CLR=0, FL=0: all state held, including CNT.
- Data words advance regardless of VI; invalid words still shift (Q carries them with VO=0).
- Q = s[DEPTH-1], VO = v[DEPTH-1], EMPTY = (CNT==0); all driven directly from registers/compare, no combinational path from D, VI, CE or FL.

## Timing
- Reset values: Q=INIT, VO=0, CNT=0, EMPTY=1, from the first edge with CLR=1.
- Latency: a word presented with CE=1 at edge k appears on Q/VO after DEPTH enabled edges; with CE held high, at edge k+DEPTH−1 output visible in the following cycle (DEPTH cycles total).
- Stalls (CE=0) stretch latency cycle-for-cycle; no word lost or duplicated.
- CLR or FL asserted mid-stream: effect visible one cycle after the edge; words in flight are lost (valid) or invalidated (FL keeps data).
- CLR released: pipeline accepts D on the first edge with CLR=0, CE=1.
- FL and CLR both high: CLR result (data to INIT).

## Test plan
- WIDTH=8, DEPTH=3, INIT=8'hA5: CLR=1 one edge -> Q=8'hA5, VO=0, CNT=0, EMPTY=1.
- CE=1, VI=1, D=8'h01,02,03,04 on consecutive edges -> Q=01,02,03,04 with VO=1 on edges 3..6; CNT rises 1,2,3 then holds 3.
- Same stream with CE=0 for two cycles after 8'h02 -> Q/CNT frozen both cycles, order 01,02,03,04 preserved, latency +2.
- Load 3 valid words (CNT=3), FL=1 with CE=1, D=8'hFF -> CNT=0, VO=0, EMPTY=1, Q keeps last data; 8'hFF never appears with VO=1.
- VI pattern 1,0,1 with D=10,20,30, CE=1 -> Q=10(VO=1),20(VO=0),30(VO=1); CNT peaks at 2.
- CLR and FL together mid-stream -> Q=8'hA5, CNT=0; DEPTH=1 build: Q follows D one enabled edge later.
